// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the default line-rate constants
// used by the transmitter, the receiver and uart_top.
package uart_pkg;

    localparam int UART_CLK_DIV   = 27;
    localparam int UART_OVS       = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick generator: one-clock pulse every CLK_DIV system clocks.
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled 8N1 UART receiver with false-start filter, framing-error and
// overrun detection, presenting bytes through a rdy/rdy_clr handshake.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV,
    parameter int OVS       = UART_OVS,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic                 rdy_clr_i,
    output logic                 rdy_o,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int SW = cnt_width(OVS);
    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rx_s;
    logic                 tick;

    uart_state_e          state_q;
    logic [SW-1:0]        samp_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 rdy_q;
    logic                 busy_q;
    logic                 fe_q;
    logic                 ov_q;

    uart_os_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tick_o (tick)
    );

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            // Acknowledge first; a completion on the same edge overrides it below.
            if (rdy_clr_i) begin
                rdy_q <= 1'b0;
                fe_q  <= 1'b0;
                ov_q  <= 1'b0;
            end
            if (tick) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_q <= ST_START;
                            samp_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (samp_q == SAMP_MID) begin
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                samp_q  <= '0;
                                bit_q   <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            samp_q <= samp_q + SW'(1);
                        end
                    end
                    ST_DATA: begin
                        if (samp_q == SAMP_LAST) begin
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            samp_q  <= '0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            samp_q <= samp_q + SW'(1);
                        end
                    end
                    ST_STOP: begin
                        // Decide at mid stop bit so a back-to-back start edge is not missed.
                        if (samp_q == SAMP_LAST) begin
                            if (rx_s) begin
                                if (rdy_q && !rdy_clr_i) begin
                                    ov_q <= 1'b1;
                                end else begin
                                    dout_q <= shift_q;
                                    rdy_q  <= 1'b1;
                                end
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                fe_q    <= 1'b1;
                                state_q <= ST_WAIT_IDLE;
                            end
                        end else begin
                            samp_q <= samp_q + SW'(1);
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rdy_o       = rdy_q;
    assign dout_o      = dout_q;
    assign busy_o      = busy_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;

endmodule
